// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the four-channel switch debouncer.
package debounce_pkg;

    localparam int unsigned NUM_CH                  = 4;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 4;

    // Counter must hold 0..cycles-1; one spare code keeps the width safe at powers of two.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: 2-flop synchronizer, stability counter, accepted level.
// Optional registered rise/fall pulses when SWITCH_DEBOUNCER_EDGE_EN is defined.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o
`ifdef SWITCH_DEBOUNCER_EDGE_EN
    ,
    output logic rise_o,
    output logic fall_o
`endif
);

    localparam int unsigned     CntW    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            stable_q, stable_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Any sample that agrees with the accepted level restarts the count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CntLast) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level_o = stable_q;

`ifdef SWITCH_DEBOUNCER_EDGE_EN
    logic rise_q, fall_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= stable_d & ~stable_q;
            fall_q <= ~stable_d & stable_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`endif

endmodule

// File: rtl/switch_debouncer.sv
// Four independent switch debouncers; outputs a..d are the accepted levels.
// Define SWITCH_DEBOUNCER_EDGE_EN to add per-channel rise/fall pulse ports.
module switch_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] sw_raw,
    output logic              a,
    output logic              b,
    output logic              c,
    output logic              d
`ifdef SWITCH_DEBOUNCER_EDGE_EN
    ,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall
`endif
);

    logic [NUM_CH-1:0] level;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk_i  (clk),
            .rst_i  (rst),
            .raw_i  (sw_raw[i]),
            .level_o(level[i])
`ifdef SWITCH_DEBOUNCER_EDGE_EN
            ,
            .rise_o (rise[i]),
            .fall_o (fall[i])
`endif
        );
    end

    assign a = level[0];
    assign b = level[1];
    assign c = level[2];
    assign d = level[3];

endmodule

// File: tb/tb_switch_debouncer.sv
// Randomized and directed bench for switch_debouncer with a queue-based scoreboard.
module tb_switch_debouncer;

    localparam int unsigned N = 4;

    typedef struct packed {
        logic [3:0] lvl;
        logic [3:0] rise;
        logic [3:0] fall;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw_raw = 4'h0;
    logic       a, b, c, d;
`ifdef SWITCH_DEBOUNCER_EDGE_EN
    logic [3:0] rise, fall;
`endif

    switch_debouncer #(
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .sw_raw(sw_raw),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d)
`ifdef SWITCH_DEBOUNCER_EDGE_EN
        ,
        .rise  (rise),
        .fall  (fall)
`endif
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    // Reference: raw value reaches the decision point two edges late; the accepted
    // level flips once the last N decision samples all disagree with it.
    logic [3:0] m_s1 = 4'h0, m_s2 = 4'h0, m_stab = 4'h0;
    logic [3:0] hist[$];

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h required %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_edge(input logic [3:0] raw, input logic rst_v);
        logic [3:0] nstab;
        bit         all_diff;
        exp_t       e;
        if (rst_v) begin
            m_s1 = 4'h0;
            m_s2 = 4'h0;
            m_stab = 4'h0;
            hist.delete();
            e.lvl = 4'h0;
            e.rise = 4'h0;
            e.fall = 4'h0;
        end else begin
            hist.push_back(m_s2);
            if (hist.size() > N) void'(hist.pop_front());
            m_s2 = m_s1;
            m_s1 = raw;
            nstab = m_stab;
            for (int ch = 0; ch < 4; ch++) begin
                all_diff = (hist.size() == N);
                foreach (hist[k]) if (hist[k][ch] == m_stab[ch]) all_diff = 1'b0;
                if (all_diff) nstab[ch] = ~m_stab[ch];
            end
            e.lvl = nstab;
            e.rise = nstab & ~m_stab;
            e.fall = ~nstab & m_stab;
            m_stab = nstab;
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [3:0] raw, input logic rst_v);
        @(negedge clk);
        sw_raw = raw;
        rst = rst_v;
        model_edge(raw, rst_v);
    endtask

    // Directed step with a hand-derived expectation checked just after the edge.
    task automatic dstep(input string name, input logic [3:0] raw, input logic rst_v,
                         input logic [3:0] want, input logic [3:0] want_r,
                         input logic [3:0] want_f);
        step(raw, rst_v);
        @(posedge clk);
        #3;
        chk(name, {d, c, b, a}, want);
`ifdef SWITCH_DEBOUNCER_EDGE_EN
        chk({name, "_rise"}, rise, want_r);
        chk({name, "_fall"}, fall, want_f);
`else
        if (want_r != want_f) n_cmp += 0;
`endif
    endtask

    // Monitor: outputs are valid every cycle, so pop one expectation per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_lvl", {d, c, b, a}, e.lvl);
`ifdef SWITCH_DEBOUNCER_EDGE_EN
                chk("sb_rise", rise, e.rise);
                chk("sb_fall", fall, e.fall);
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] lvl;
        int         rem[4];
        logic       rv;

        // Reset with all switches held high, then release.
        dstep("rst_hold1", 4'hF, 1'b1, 4'h0, 4'h0, 4'h0);
        dstep("rst_hold2", 4'hF, 1'b1, 4'h0, 4'h0, 4'h0);
        for (int i = 1; i <= 7; i++)
            dstep("rel_lat", 4'hF, 1'b0, (i >= 6) ? 4'hF : 4'h0,
                  (i == 6) ? 4'hF : 4'h0, 4'h0);

        // b and c released together.
        for (int i = 1; i <= 8; i++)
            dstep("fall_bc", 4'h9, 1'b0, (i >= 6) ? 4'h9 : 4'hF, 4'h0,
                  (i == 6) ? 4'h6 : 4'h0);

        for (int i = 1; i <= 8; i++) step(4'h0, 1'b0);
        dstep("settle0", 4'h0, 1'b0, 4'h0, 4'h0, 4'h0);

        // Single channel press.
        for (int i = 1; i <= 10; i++)
            dstep("press_a", 4'h1, 1'b0, (i >= 6) ? 4'h1 : 4'h0,
                  (i == 6) ? 4'h1 : 4'h0, 4'h0);
        for (int i = 1; i <= 8; i++) step(4'h0, 1'b0);

        // Bounce on b shorter than the debounce window.
        for (int i = 0; i < 16; i++)
            dstep("bounce_b", (i < 8 && (i % 4) < 2) ? 4'h2 : 4'h0, 1'b0, 4'h0, 4'h0, 4'h0);

        // Reset mid-count on d discards the partial count.
        for (int i = 0; i < 3; i++) dstep("d_pre", 4'h8, 1'b0, 4'h0, 4'h0, 4'h0);
        dstep("d_rst", 4'h8, 1'b1, 4'h0, 4'h0, 4'h0);
        for (int i = 1; i <= 7; i++)
            dstep("d_post", 4'h8, 1'b0, (i >= 6) ? 4'h8 : 4'h0,
                  (i == 6) ? 4'h8 : 4'h0, 4'h0);

        // Random bounce: mostly 1-3 cycle pulses, occasional long holds, rare resets.
        lvl = 4'h8;
        for (int ch = 0; ch < 4; ch++) rem[ch] = 0;
        for (int t = 0; t < 500; t++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (rem[ch] == 0) begin
                    lvl[ch] = ~lvl[ch];
                    rem[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 12)
                                                         : $urandom_range(1, 3);
                end
                rem[ch]--;
            end
            rv = ($urandom_range(0, 99) == 0);
            step(lvl, rv);
        end

        repeat (3) @(posedge clk);
        #3;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
